jk_ff_arbiter: RTL

Round-robin arbiter that shares one `jk_ff` storage bit among `N_REQ` requesters. Each requester posts a J/K command (hold, reset, set, toggle) with a req/ack handshake. The arbiter grants one requester at a time, applies its command to the flip-flop for exactly one clock, and acknowledges once the new `q` is visible. It is the top-level controller on the Basys3 board for any switch- or FSM-driven logic that must update the same JK bit.

---
 rtl/jk_arb_pkg.sv | 16 +
 rtl/jk_ff.sv | 26 ++
 rtl/jk_rr_pick.sv | 29 ++
 rtl/jk_ff_arbiter.sv | 102 ++++++++++
 4 files changed

// File: rtl/jk_arb_pkg.sv
// Shared definitions for the round-robin arbiter around the JK storage bit:
// J/K command codes and the arbiter FSM state encoding.
package jk_arb_pkg;

    localparam logic [1:0] CMD_HOLD = 2'b00;
    localparam logic [1:0] CMD_RST  = 2'b01;
    localparam logic [1:0] CMD_SET  = 2'b10;
    localparam logic [1:0] CMD_TGL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/jk_ff.sv
// Single JK flip-flop with synchronous active-high reset; {j,k} uses the
// command encoding from jk_arb_pkg.
module jk_ff
    import jk_arb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                CMD_RST: q <= 1'b0;
                CMD_SET: q <= 1'b1;
                CMD_TGL: q <= ~q;
                default: q <= q;
            endcase
        end
    end

endmodule

// File: rtl/jk_rr_pick.sv
// Combinational round-robin picker: first set request bit searching upward
// from ptr+1 (wrapping), so the previous winner has lowest priority.
module jk_rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  win,
    output logic             vld
);

    logic [ID_W-1:0] cand;

    always_comb begin
        win  = '0;
        vld  = 1'b0;
        cand = '0;
        // off == N_REQ lands back on ptr itself, so a lone requester still wins.
        for (int off = 1; off <= N_REQ; off++) begin
            cand = ID_W'((int'(ptr) + off) % N_REQ);
            if (!vld && req[cand]) begin
                win = cand;
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/jk_ff_arbiter.sv
// Round-robin arbiter sharing one JK flip-flop among N_REQ requesters:
// IDLE arbitrates, APPLY drives the latched command for one clock, DONE acks.
module jk_ff_arbiter
    import jk_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [2*N_REQ-1:0] cmd,
    output logic [N_REQ-1:0]   ack,
    output logic               busy,
    output logic [ID_W-1:0]    grant_id,
    output logic               j,
    output logic               k,
    output logic               q
);

    state_t          state;
    state_t          state_nxt;
    logic [ID_W-1:0] ptr;
    logic [1:0]      cmd_lat;
    logic [1:0]      cmd_sel;
    logic [ID_W-1:0] pick_id;
    logic            pick_vld;
    logic            take;

    jk_rr_pick #(
        .N_REQ(N_REQ),
        .ID_W (ID_W)
    ) u_pick (
        .req(req),
        .ptr(ptr),
        .win(pick_id),
        .vld(pick_vld)
    );

    jk_ff u_ff (
        .clk  (clk),
        .reset(reset),
        .j    (j),
        .k    (k),
        .q    (q)
    );

    assign take = (state == ST_IDLE) && pick_vld;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        j         = 1'b0;
        k         = 1'b0;
        case (state)
            ST_IDLE:  if (pick_vld) state_nxt = ST_APPLY;
            ST_APPLY: begin
                state_nxt = ST_DONE;
                {j, k}    = cmd_lat;
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_sel = CMD_HOLD;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_id == ID_W'(i)) cmd_sel = cmd[2*i +: 2];
        end
    end

    // busy/ack are flops fed from the next state, so neither has a path from req.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr      <= ID_W'(N_REQ - 1);
            grant_id <= '0;
            busy     <= 1'b0;
            ack      <= '0;
        end else begin
            busy <= (state_nxt != ST_IDLE);
            ack  <= '0;
            if (take) begin
                grant_id <= pick_id;
                ptr      <= pick_id;
            end
            if (state == ST_APPLY) ack[grant_id] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (take) cmd_lat <= cmd_sel;
    end

endmodule
